// File: rtl/uart_array_tx.sv
// UART transmitter for a latched byte array: NUM_BYTES back-to-back
// 8N1 frames, byte 0 first, LSB first, with busy/done status.
module uart_array_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int NUM_BYTES    = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [8*NUM_BYTES-1:0] sorted_array,
   input  logic                   array_is_sorted,
   output logic                   tx,
   output logic                   tx_busy,
   output logic                   tx_done
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int YW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [YW-1:0] BYTE_LAST = YW'(NUM_BYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t                      state_q, state_d;
   logic [BW-1:0]               baud_q, baud_d;
   logic [2:0]                  bit_q, bit_d;
   logic [YW-1:0]               byte_q, byte_d;
   logic [NUM_BYTES-1:0][7:0]   buf_q, buf_d;
   logic                        tx_q, tx_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic                        bit_end;
   logic [2:0]                  nxt_bit;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      buf_d   = buf_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      bit_end = (baud_q == BAUD_LAST);
      nxt_bit = bit_q + 3'd1;

      if (state_q != S_IDLE) begin
         baud_d = bit_end ? '0 : baud_q + 1'b1;
      end

      // tx is computed one cycle ahead so the pin comes straight from a flop
      unique case (state_q)
         S_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (array_is_sorted) begin
               buf_d   = sorted_array;
               byte_d  = '0;
               baud_d  = '0;
               state_d = S_START;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               bit_d   = '0;
               tx_d    = buf_q[byte_q][0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
                  bit_d   = '0;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = nxt_bit;
                  tx_d  = buf_q[byte_q][nxt_bit];
               end
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (byte_q != BYTE_LAST) begin
                  byte_d  = byte_q + 1'b1;
                  state_d = S_START;
                  tx_d    = 1'b0;
               end else begin
                  state_d = S_IDLE;
                  tx_d    = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         buf_q   <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         buf_q   <= buf_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign tx      = tx_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;

endmodule

// File: tb/tb_uart_array_tx.sv
// Bench for uart_array_tx: per-cycle waveform model, frame decoding,
// start-while-busy, back-to-back, async reset and minimum divisor.
module tb_uart_array_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] sa  = '0;
   logic        ast = 1'b0;
   logic        tx1, busy1, done1;
   logic        tx2, busy2, done2;
   int          nchk = 0;
   int          nerr = 0;
   int          cyc  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_array_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(8)) dut (
      .clk(clk), .rst(rst), .sorted_array(sa),
      .array_is_sorted(ast),
      .tx(tx1), .tx_busy(busy1), .tx_done(done1)
   );

   uart_array_tx #(.CLKS_PER_BIT(2), .NUM_BYTES(8)) dut2 (
      .clk(clk), .rst(rst), .sorted_array(sa),
      .array_is_sorted(ast),
      .tx(tx2), .tx_busy(busy2), .tx_done(done2)
   );

   typedef struct {
      logic [63:0] data;
      logic [63:0] stream;
   } vec_t;

   vec_t vt [4];

   task automatic chk(input string nm, input logic a, input logic e);
      nchk++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, a, e);
      end
   endtask

   task automatic chk64(input string nm, input logic [63:0] a,
                        input logic [63:0] e);
      nchk++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s got=%h want=%h", nm, a, e);
      end
   endtask

   // Line level j cycles after the start was sampled, from frame arithmetic
   function automatic logic exp_tx(input logic [63:0] d, input int j,
                                   input int cpb);
      int m, by, pos;
      m   = (j - 1) / cpb;
      by  = m / 10;
      pos = m % 10;
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      return d[8*by + pos - 1];
   endfunction

   function automatic logic [63:0] order(input logic [63:0] d);
      logic [63:0] r;
      for (int k = 0; k < 8; k++) r[63-8*k -: 8] = d[8*k +: 8];
      return r;
   endfunction

   task automatic start(input logic [63:0] d);
      @(negedge clk);
      sa  = d;
      ast = 1'b1;
      @(posedge clk);
   endtask

   task automatic run(input logic [63:0] d, input bit two, input int inj,
                      input bit chain, input logic [63:0] nxt,
                      input int last, output logic [63:0] st);
      int cpb, tot, m, pos;
      logic t, b, dn;
      logic [7:0] sh;
      cpb = two ? 2 : 4;
      tot = 80 * cpb;
      st  = '0;
      sh  = '0;
      for (int j = 1; j <= last; j++) begin
         @(negedge clk);
         if (j == 1) ast = 1'b0;
         t  = two ? tx2 : tx1;
         b  = two ? busy2 : busy1;
         dn = two ? done2 : done1;
         if (j <= tot) begin
            chk("tx", t, exp_tx(d, j, cpb));
            chk("busy", b, 1'b1);
            chk("done_early", dn, 1'b0);
            m   = (j - 1) / cpb;
            pos = m % 10;
            if (pos >= 1 && pos <= 8 && (j - 1) % cpb == cpb / 2)
               sh = {t, sh[7:1]};
            if (pos == 9 && (j - 1) % cpb == 0)
               st = {st[55:0], sh};
         end else begin
            chk("tx_idle", t, 1'b1);
            chk("busy_end", b, 1'b0);
            chk("done", dn, (j == tot + 1));
         end
         if (j == inj) begin
            sa  = '1;
            ast = 1'b1;
         end
         if (inj > 0 && j == inj + 1) ast = 1'b0;
         if (chain && j == tot) begin
            sa  = nxt;
            ast = 1'b1;
         end
      end
   endtask

   logic [63:0] st;

   initial begin
      vt[0] = '{64'h0807_0605_0403_0201, 64'h0102_0304_0506_0708};
      vt[1] = '{64'h00FF_00FF_00FF_00FF, 64'hFF00_FF00_FF00_FF00};
      vt[2] = '{64'h1122_3344_5566_7788, 64'h8877_6655_4433_2211};
      vt[3] = '{64'h8001_7F80_C3A5_5A3C, 64'h3C5A_A5C3_807F_0180};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tx", tx1, 1'b1);
      chk("rst_busy", busy1, 1'b0);
      chk("rst_done", done1, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_tx", tx1, 1'b1);
         chk("idle_busy", busy1, 1'b0);
         chk("idle_done", done1, 1'b0);
         chk("idle_tx2", tx2, 1'b1);
      end

      for (int i = 0; i < 4; i++) begin
         start(vt[i].data);
         run(vt[i].data, 1'b0, 0, 1'b0, '0, 323, st);
         chk64("stream", st, vt[i].stream);
      end

      start(vt[0].data);
      run(vt[0].data, 1'b0, 90, 1'b0, '0, 330, st);
      chk64("busy_start", st, vt[0].stream);

      start(vt[0].data);
      run(vt[0].data, 1'b0, 0, 1'b1, vt[1].data, 321, st);
      chk64("b2b_first", st, vt[0].stream);
      run(vt[1].data, 1'b0, 0, 1'b0, '0, 323, st);
      chk64("b2b_second", st, vt[1].stream);

      start(64'h0807_0605_0403_0201);
      run(64'h0807_0605_0403_0201, 1'b0, 0, 1'b0, '0, 138, st);
      #2 rst = 1'b1;
      #1;
      chk("arst_tx", tx1, 1'b1);
      chk("arst_busy", busy1, 1'b0);
      chk("arst_done", done1, 1'b0);
      repeat (2) begin
         @(negedge clk);
         chk("arst_hold_done", done1, 1'b0);
      end
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("post_rst_done", done1, 1'b0);
         chk("post_rst_tx", tx1, 1'b1);
      end
      start(vt[2].data);
      run(vt[2].data, 1'b0, 0, 1'b0, '0, 323, st);
      chk64("after_rst", st, vt[2].stream);

      for (int r = 0; r < 3; r++) begin
         logic [63:0] d;
         d = {$urandom, $urandom};
         start(d);
         run(d, 1'b0, 0, 1'b0, '0, 323, st);
         chk64("rand_stream", st, order(d));
      end

      start(64'h0);
      run(64'h0, 1'b1, 0, 1'b0, '0, 163, st);
      chk64("cpb2_stream", st, 64'h0);
      repeat (200) @(negedge clk);
      start(vt[3].data);
      run(vt[3].data, 1'b1, 0, 1'b0, '0, 163, st);
      chk64("cpb2_data", st, vt[3].stream);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
